// File: rtl/data_mem_port.sv
// Word-organised data RAM behind mem_controller: byte/half/word lanes,
// right-justified loads, 2-cycle read-modify-write for sub-word stores.
// Ports: clk, rst_n, req, we, size[1:0], addr[SIZE-1:0], wdata[31:0] in;
//        ready, rdata[31:0], rvalid, misalign out.
module data_mem_port #(
  parameter int SIZE  = 12,
  parameter int DEPTH = 2**(SIZE-2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic [SIZE-1:0] addr,
  input  logic [31:0]     wdata,
  output logic            ready,
  output logic [31:0]     rdata,
  output logic            rvalid,
  output logic            misalign
);

  localparam int IW = SIZE - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RMW_RD = 2'd1;
  localparam logic [1:0] S_RMW_WR = 2'd2;

  logic [31:0]   r_mem [DEPTH];
  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [1:0]    r_size;
  logic [15:0]   r_wdata;
  logic [31:0]   r_merge;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_misalign;

  logic [IW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_accept;
  logic          w_mis;
  logic          w_load;
  logic          w_word_st;
  logic          w_sub_st;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_ldata;
  logic [31:0]   w_mask;
  logic [31:0]   w_ins;
  logic [31:0]   w_merged;

  assign w_idx    = addr[SIZE-1:2];
  assign w_lane   = addr[1:0];
  assign ready    = (r_state == S_IDLE);
  assign w_accept = req && ready;

  always_comb begin
    w_mis = 1'b0;
    unique case (1'b1)
      (size == 2'b00): w_mis = 1'b0;
      (size == 2'b01): w_mis = addr[0];
      (size == 2'b10): w_mis = (addr[1:0] != 2'b00);
      default:         w_mis = 1'b1;
    endcase
  end

  assign w_load    = w_accept && !w_mis && !we;
  assign w_word_st = w_accept && !w_mis && we && (size == 2'b10);
  assign w_sub_st  = w_accept && !w_mis && we && (size != 2'b10);

  // Load path: select addressed lane, right-justify, clear upper bits
  assign w_rd_word = r_mem[w_idx];
  assign w_shift   = w_rd_word >> {w_lane, 3'b000};

  always_comb begin
    w_ldata = w_shift;
    unique case (1'b1)
      (size == 2'b00): w_ldata = {24'b0, w_shift[7:0]};
      (size == 2'b01): w_ldata = {16'b0, w_shift[15:0]};
      default:         w_ldata = w_shift;
    endcase
  end

  // Merge: replace only the latched lane of the word read in RMW_RD
  assign w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF)
                    << {r_lane, 3'b000};
  assign w_ins    = {16'b0, r_wdata} << {r_lane, 3'b000};
  assign w_merged = (r_merge & ~w_mask) | (w_ins & w_mask);

  // RAM array is not reset; rst_n gating keeps a write from landing
  // while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_word_st)
        r_mem[w_idx] <= wdata;
      else if (r_state == S_RMW_WR)
        r_mem[r_idx] <= w_merged;
      if (r_state == S_RMW_RD)
        r_merge <= r_mem[r_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_lane     <= 2'b00;
      r_size     <= 2'b00;
      r_wdata    <= 16'b0;
      r_rdata    <= 32'b0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_rvalid   <= w_load;
      r_misalign <= w_accept && w_mis;
      if (w_load)
        r_rdata <= w_ldata;
      unique case (r_state)
        S_IDLE: begin
          if (w_sub_st) begin
            r_idx   <= w_idx;
            r_lane  <= w_lane;
            r_size  <= size;
            r_wdata <= wdata[15:0];
            r_state <= S_RMW_RD;
          end
        end
        S_RMW_RD: r_state <= S_RMW_WR;
        S_RMW_WR: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign rvalid   = r_rvalid;
  assign misalign = r_misalign;

endmodule
